instr_exec_responder: RTL and testbench

- Responder end of the fetch/decode handshake. Accepts a 59-bit instruction with a start request and acknowledges it with busy.
- Decodes and executes the instruction on an 8-entry register file, then reports completion with done, fetch_stage_enable and next_pc_to_cpu.
- Sits beside the CPU fetch sequencer as the execution engine that the fetch side polls.

---
 rtl/instr_exec_responder.sv | 186 ++++++++++++++++++
 tb/tb_instr_exec_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_responder.sv
// instr_exec_responder
//   Execution engine on the responder side of the fetch/decode handshake.
//   Accepts a 59-bit instruction on start (sampled only in IDLE), raises busy,
//   decodes and executes it against an 8-entry register file, then retires it
//   with a one-cycle done pulse, the next program counter and a level
//   fetch_stage_enable that the fetch side polls.
//
//   Optional feature (define INSTR_EXEC_RETIRE_CNT_EN): adds a 16-bit
//   retire_count output that increments on every retirement, HALT included.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   start, instruction  request and instruction word from the fetch side
//   busy                instruction in flight (registered)
//   done                one-cycle retirement pulse
//   fetch_stage_enable  fetch side may fetch next_pc_to_cpu
//   next_pc_to_cpu      address of the next instruction
//   halted              HALT has retired
//   illegal_op          sticky: an undefined opcode was executed
//   dbg_addr, dbg_data  combinational register file read port
//   retire_count        (optional) retirement counter
module instr_exec_responder #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [58:0]       instruction,
  output logic              busy,
  output logic              done,
  output logic              fetch_stage_enable,
  output logic [PC_W-1:0]   next_pc_to_cpu,
  output logic              halted,
  output logic              illegal_op,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef INSTR_EXEC_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MUL_ITER, S_COMPLETE, S_HALTED
  } state_t;

  state_t state_q, state_d;

  logic        [58:0]       ir;
  logic signed [DATA_W-1:0] rf [8];
  logic signed [DATA_W-1:0] op_a, op_b;
  logic                     br_eq;
  logic signed [DATA_W-1:0] mul_acc, mul_mcand;
  logic        [DATA_W-1:0] mul_mplier;
  logic        [CNT_W-1:0]  mul_cnt;
  logic        [PC_W-1:0]   pc, next_pc_q;

  logic [3:0]               opcode;
  logic [2:0]               rd, rs1, rs2;
  logic [PC_W-1:0]          target;
  logic signed [DATA_W-1:0] imm_v;
  logic signed [DATA_W-1:0] alu_res;
  logic                     wr_en;
  logic [PC_W-1:0]          pc_inc, next_pc_d;

  assign opcode = ir[58:55];
  assign rd     = ir[54:52];
  assign rs1    = ir[51:49];
  assign rs2    = ir[48:46];
  assign target = PC_W'(ir[45:41]);
  assign imm_v  = DATA_W'(ir[40:25]);
  assign pc_inc = pc + PC_W'(1);

  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_DECODE;
      S_DECODE:   state_d = (opcode == OP_MUL) ? S_MUL_ITER : S_EXEC;
      S_MUL_ITER: if (mul_cnt == CNT_W'(1)) state_d = S_EXEC;
      S_EXEC:     state_d = S_COMPLETE;
      S_COMPLETE: state_d = (opcode == OP_HALT) ? S_HALTED : S_IDLE;
      S_HALTED:   state_d = S_HALTED;
      default:    state_d = S_IDLE;
    endcase
  end

  // Write-back value and branch target, consumed in EXEC.
  always_comb begin
    alu_res   = '0;
    wr_en     = 1'b0;
    next_pc_d = pc_inc;
    case (opcode)
      OP_ADD: begin alu_res = op_a + op_b; wr_en = 1'b1; end
      OP_SUB: begin alu_res = op_a - op_b; wr_en = 1'b1; end
      OP_LDI: begin alu_res = imm_v;       wr_en = 1'b1; end
      OP_MUL: begin alu_res = mul_acc;     wr_en = 1'b1; end
      OP_JMP: next_pc_d = target;
      OP_BEQ: next_pc_d = br_eq ? target : pc_inc;
      default: ;
    endcase
  end

  // Operand/scratch registers need no reset: they are always loaded in
  // DECODE before being used.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE:   if (start) ir <= instruction;
      S_DECODE: begin
        op_a       <= rf[rs1];
        op_b       <= rf[rs2];
        br_eq      <= (rf[rs1] == rf[rs2]);
        mul_acc    <= '0;
        mul_mcand  <= rf[rs1];
        mul_mplier <= $unsigned(rf[rs2]);
        mul_cnt    <= CNT_W'(DATA_W);
      end
      // One multiplier bit per cycle; only the low DATA_W product bits are kept.
      S_MUL_ITER: begin
        if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
        mul_mcand  <= mul_mcand <<< 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy               <= 1'b0;
      done               <= 1'b0;
      fetch_stage_enable <= 1'b0;
      next_pc_to_cpu     <= '0;
      halted             <= 1'b0;
      illegal_op         <= 1'b0;
      pc                 <= '0;
      next_pc_q          <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
`ifdef INSTR_EXEC_RETIRE_CNT_EN
      retire_count       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE:   if (start) fetch_stage_enable <= 1'b0;
        S_DECODE: busy <= 1'b1;
        S_EXEC: begin
          if (wr_en) rf[rd] <= alu_res;
          if (opcode[3]) illegal_op <= 1'b1;
          next_pc_q <= next_pc_d;
        end
        S_COMPLETE: begin
          busy           <= 1'b0;
          done           <= 1'b1;
          next_pc_to_cpu <= next_pc_q;
          pc             <= next_pc_q;
          if (opcode == OP_HALT) halted <= 1'b1;
          else                   fetch_stage_enable <= 1'b1;
`ifdef INSTR_EXEC_RETIRE_CNT_EN
          retire_count   <= retire_count + 16'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_responder.sv
// Scoreboard bench for instr_exec_responder: a reference model computes the
// expected register value, next PC, latency and status flags when an
// instruction is driven; the entry is popped and compared at done.
module tb_instr_exec_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [58:0] instruction;
  logic        busy, done, fetch_stage_enable, halted, illegal_op;
  logic [4:0]  next_pc_to_cpu;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef INSTR_EXEC_RETIRE_CNT_EN
  logic [15:0] retire_count;
`endif

  instr_exec_responder #(.DATA_W(16), .PC_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .instruction        (instruction),
    .busy               (busy),
    .done               (done),
    .fetch_stage_enable (fetch_stage_enable),
    .next_pc_to_cpu     (next_pc_to_cpu),
    .halted             (halted),
    .illegal_op         (illegal_op),
    .dbg_addr           (dbg_addr),
    .dbg_data           (dbg_data)
`ifdef INSTR_EXEC_RETIRE_CNT_EN
    ,
    .retire_count       (retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  npc;
    logic [2:0]  addr;
    logic [15:0] val;
    int          lat;
    logic        halt;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  logic [15:0] mregs [8];
  logic [4:0]  mpc;
  logic        mhalt, mill;
  int          ret_cnt;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mpc = '0; mhalt = 1'b0; mill = 1'b0; ret_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Model the instruction, push the expectation, drive it, and compare at done.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [4:0] tgt, input logic [15:0] imm);
    exp_t        e;
    logic [15:0] a, b;
    logic [31:0] prod;
    logic [4:0]  nxt;
    bit          seen_done, busy_ok;
    int          lat_seen;
    a = mregs[rs1]; b = mregs[rs2];
    nxt = mpc + 5'd1;
    e.lat = 3;
    case (op)
      4'd1: mregs[rd] = a + b;
      4'd2: mregs[rd] = a - b;
      4'd3: mregs[rd] = imm;
      4'd4: begin prod = 32'(a) * 32'(b); mregs[rd] = prod[15:0]; e.lat = 19; end
      4'd5: nxt = tgt;
      4'd6: nxt = (a == b) ? tgt : mpc + 5'd1;
      4'd7: mhalt = 1'b1;
      4'd0: ;
      default: mill = 1'b1;
    endcase
    mpc = nxt;
    e.npc = nxt; e.addr = rd; e.val = mregs[rd]; e.halt = mhalt; e.ill = mill;
    sb.push_back(e);

    @(negedge clk);
    instruction = {op, rd, rs1, rs2, tgt, imm, 25'h0};
    start = 1'b1;
    dbg_addr = rd;
    @(posedge clk);
    seen_done = 0; busy_ok = 1; lat_seen = 0;
    for (int n = 1; n <= 40 && !seen_done; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("busy_t1", {31'b0, busy}, 32'd1);
      if (busy) start = 1'b0;
      if (done) begin seen_done = 1; lat_seen = n; end
      else if (!busy) busy_ok = 0;
    end
    start = 1'b0;
    if (!seen_done) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      ret_cnt++;
      e = sb.pop_front();
      chk("latency", 32'(lat_seen), 32'(e.lat));
      chk("busy_held", {31'b0, busy_ok}, 32'd1);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      chk("next_pc", {27'b0, next_pc_to_cpu}, {27'b0, e.npc});
      chk("fetch_en", {31'b0, fetch_stage_enable}, {31'b0, ~e.halt});
      chk("halted", {31'b0, halted}, {31'b0, e.halt});
      chk("illegal", {31'b0, illegal_op}, {31'b0, e.ill});
      chk("rd_value", {16'b0, dbg_data}, {16'b0, e.val});
      @(posedge clk); #1;
      chk("done_pulse", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    bit any_act;
    rst = 1'b1; start = 1'b0; instruction = '0; dbg_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fetch_en", {31'b0, fetch_stage_enable}, 32'd0);
    chk("rst_npc", {27'b0, next_pc_to_cpu}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst_reg0", {16'b0, dbg_data}, 32'd0);

    issue(4'd3, 3'd1, 3'd0, 3'd0, 5'd0, 16'd5);       // LDI r1=5
    issue(4'd3, 3'd1, 3'd0, 3'd0, 5'd0, 16'hFFFF);    // LDI r1=FFFF
    issue(4'd3, 3'd2, 3'd0, 3'd0, 5'd0, 16'd2);       // LDI r2=2
    issue(4'd1, 3'd3, 3'd1, 3'd2, 5'd0, 16'd0);       // ADD r3=r1+r2
    issue(4'd2, 3'd4, 3'd2, 3'd1, 5'd0, 16'd0);       // SUB r4=r2-r1
    issue(4'd3, 3'd1, 3'd0, 3'd0, 5'd0, 16'd300);
    issue(4'd3, 3'd2, 3'd0, 3'd0, 5'd0, 16'd200);
    issue(4'd4, 3'd5, 3'd1, 3'd2, 5'd0, 16'd0);       // MUL r5
    issue(4'd5, 3'd0, 3'd0, 3'd0, 5'd31, 16'd0);      // JMP 31
    issue(4'd0, 3'd0, 3'd0, 3'd0, 5'd0, 16'd0);       // NOP at 31 -> 0
    issue(4'd5, 3'd0, 3'd0, 3'd0, 5'd31, 16'd0);      // JMP 31
    issue(4'd6, 3'd0, 3'd1, 3'd1, 5'd12, 16'd0);      // BEQ taken
    issue(4'd6, 3'd0, 3'd1, 3'd2, 5'd20, 16'd0);      // BEQ not taken
    issue(4'd5, 3'd0, 3'd0, 3'd0, 5'd7, 16'd0);       // JMP 7
    issue(4'd1, 3'd2, 3'd2, 3'd2, 5'd0, 16'd0);       // ADD r2=r2+r2 (rd==rs)
    issue(4'd9, 3'd3, 3'd1, 3'd2, 5'd0, 16'h1234);    // illegal
    issue(4'd0, 3'd3, 3'd0, 3'd0, 5'd0, 16'd0);       // NOP, illegal sticky
    issue(4'd7, 3'd0, 3'd0, 3'd0, 5'd0, 16'd0);       // HALT

`ifdef INSTR_EXEC_RETIRE_CNT_EN
    chk("retire_count", {16'b0, retire_count}, 32'(ret_cnt));
`endif

    // Start after HALT must be ignored.
    @(negedge clk);
    instruction = {4'd3, 3'd1, 3'd0, 3'd0, 5'd0, 16'd77, 25'h0};
    start = 1'b1;
    any_act = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (busy || done) any_act = 1;
    end
    start = 1'b0;
    chk("halt_ignores_start", {31'b0, any_act}, 32'd0);
    chk("halted_stays", {31'b0, halted}, 32'd1);

    do_reset();
    issue(4'd3, 3'd1, 3'd0, 3'd0, 5'd0, 16'd3);
    issue(4'd3, 3'd2, 3'd0, 3'd0, 5'd0, 16'd4);

    // MUL interrupted by reset in its eighth iteration.
    @(negedge clk);
    instruction = {4'd4, 3'd6, 3'd1, 3'd2, 5'd0, 16'd0, 25'h0};
    start = 1'b1;
    dbg_addr = 3'd6;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (busy) start = 1'b0;
    end
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("mulrst_busy", {31'b0, busy}, 32'd0);
    chk("mulrst_done", {31'b0, done}, 32'd0);
    chk("mulrst_npc", {27'b0, next_pc_to_cpu}, 32'd0);
    chk("mulrst_fetch_en", {31'b0, fetch_stage_enable}, 32'd0);
    chk("mulrst_rd", {16'b0, dbg_data}, 32'd0);
    dbg_addr = 3'd1; #1;
    chk("mulrst_r1", {16'b0, dbg_data}, 32'd0);

    issue(4'd3, 3'd2, 3'd0, 3'd0, 5'd0, 16'd9);       // recovers from pc 0
    issue(4'd4, 3'd7, 3'd2, 3'd2, 5'd0, 16'd0);       // MUL r7 = 81

`ifdef INSTR_EXEC_RETIRE_CNT_EN
    chk("retire_count_after_rst", {16'b0, retire_count}, 32'(ret_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
